// File: rtl/dot_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// dot_accumulator_pkg
// Shared definitions for the dot-product accumulator:
//   state_e      - accumulator FSM states (IDLE / ACCUM / HOLD)
//   DEF_ACC_W    - default accumulator / result width
//   DEF_MAX_LEN  - default maximum beats per vector
//   IN_W         - width of one partial-sum beat from the multiply-add stage
//   cnt_width()  - width needed to hold a beat count of 0..max_len
// ---------------------------------------------------------------------------
package dot_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // accumulator empty, no result held
    ST_ACCUM = 2'd1,  // at least one beat summed, vector still open
    ST_HOLD  = 2'd2   // result presented, waiting for downstream
  } state_e;

  localparam int DEF_ACC_W   = 40;
  localparam int DEF_MAX_LEN = 256;
  localparam int IN_W        = 32;

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/dot_acc_adder.sv
// ---------------------------------------------------------------------------
// dot_acc_adder
// ACC_W-bit unsigned add of the running accumulator and one zero-extended
// 32-bit partial sum, with carry-out.
//
// Configuration macro: DOT_ACCUMULATOR_SAT_EN
//   defined   - on carry the sum clamps to all ones (2^ACC_W-1)
//   undefined - the sum wraps modulo 2^ACC_W
// In both builds carry_o reports that the true sum did not fit.
//
// Ports:
//   acc_i   in  ACC_W  running accumulator
//   add_i   in  32     partial-sum beat
//   sum_o   out ACC_W  wrapped or clamped sum
//   carry_o out 1      carry-out of the ACC_W-bit add
// ---------------------------------------------------------------------------
module dot_acc_adder
  import dot_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] raw_sum;

  assign raw_sum = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, add_i};
  assign carry_o = raw_sum[ACC_W];

`ifdef DOT_ACCUMULATOR_SAT_EN
  // Once clamped, any further non-zero beat carries again, so the
  // accumulator stays pinned at all ones for the rest of the vector.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
  assign sum_o = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/dot_accumulator.sv
// ---------------------------------------------------------------------------
// dot_accumulator
// Sums a stream of 32-bit partial sums into one ACC_W-bit dot product per
// vector and presents it through a single output register.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps valid and its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's ready (in_ready = ~(out_valid & ~out_ready)).
//
// A vector closes on a beat carrying in_last, or on the MAX_LEN-th beat
// (then out_trunc=1 and the next beat opens a new vector).
//
// Configuration macro: DOT_ACCUMULATOR_SAT_EN (saturating accumulation,
// see dot_acc_adder); default build wraps modulo 2^ACC_W.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  beat handshake
//   in_data  [31:0]    unsigned partial sum
//   in_last            beat is final of its vector
//   out_valid/out_ready result handshake
//   out_data [ACC_W]   dot-product result
//   out_count[CNT_W]   beats in the vector (1..MAX_LEN)
//   out_ovf            accumulation exceeded 2^ACC_W-1
//   out_trunc          vector closed by MAX_LEN, not in_last
// ---------------------------------------------------------------------------
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int CNT_W  = cnt_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_trunc_q, out_trunc_d;

  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               final_beat;

  // One adder serves both the running sum and the final total: the final
  // result is simply the running sum including the closing beat.
  dot_acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .acc_i   (acc_q),
    .add_i   (in_data),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign out_valid  = (state_q == ST_HOLD);
  assign in_ready   = ~(out_valid & ~out_ready);
  assign accept     = in_valid & in_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign final_beat = in_last | (cnt_inc == CNT_W'(MAX_LEN));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    // Result retirement first; a final beat accepted on the same edge
    // overrides it below and keeps the FSM in HOLD.
    case (state_q)
      ST_HOLD: begin
        if (out_ready) begin
          state_d = (cnt_q != '0) ? ST_ACCUM : ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (final_beat) begin
        out_data_d  = sum;
        out_count_d = cnt_inc;
        out_ovf_d   = sticky_q | carry;
        out_trunc_d = ~in_last;
        acc_d       = '0;
        cnt_d       = '0;
        sticky_d    = 1'b0;
        state_d     = ST_HOLD;
      end else begin
        acc_d    = sum;
        cnt_d    = cnt_inc;
        sticky_d = sticky_q | carry;
        state_d  = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dot_accumulator
// Bench for dot_accumulator built with ACC_W=33, MAX_LEN=4 so that wrap /
// saturation and forced vector termination occur often. A vector-level
// model (list of beats, plain integer sum) predicts the outputs; directed
// sequences with hand-computed literals pin the model, then randomized
// traffic with random downstream back-pressure runs against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dot_accumulator;

  localparam int ACC_W   = 33;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int PK_W    = ACC_W + CNT_W + 2;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

`ifdef DOT_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] OVF_RESULT = 33'h1FFFFFFFF;
`else
  localparam logic [ACC_W-1:0] OVF_RESULT = 33'h000000000;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_trunc;

  always #5 clk = ~clk;

  dot_accumulator #(
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]      beats[$];
  logic [PK_W-1:0]  exp_q[$];
  logic             m_valid = 1'b0;
  logic [ACC_W-1:0] m_data  = '0;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_ovf   = 1'b0;
  logic             m_trunc = 1'b0;

  task automatic close_vector(input logic trunc);
    longint unsigned total = 0;
    foreach (beats[i]) total += 64'(beats[i]);
    m_ovf = (total > MAXV);
`ifdef DOT_ACCUMULATOR_SAT_EN
    m_data = m_ovf ? ACC_W'(MAXV) : ACC_W'(total);
`else
    m_data = ACC_W'(total & MAXV);
`endif
    m_count = CNT_W'(beats.size());
    m_trunc = trunc;
    m_valid = 1'b1;
    exp_q.push_back({m_ovf, m_trunc, m_count, m_data});
    beats.delete();
  endtask

  initial begin : model
    logic m_acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        beats.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_count = '0;
        m_ovf   = 1'b0;
        m_trunc = 1'b0;
      end else begin
        m_acc = in_valid && !(m_valid && !out_ready);
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_acc) begin
          beats.push_back(in_data);
          if (in_last || beats.size() == MAX_LEN) close_vector(!in_last);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, !(m_valid && !out_ready));
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
          chk("out_data", out_data, m_data);
          chk("out_count", out_count, m_count);
          chk("out_ovf", out_ovf, m_ovf);
          chk("out_trunc", out_trunc, m_trunc);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire: result 0x%0h retired with no expected result queued", out_data);
          end else begin
            chk("retire", {out_ovf, out_trunc, out_count, out_data}, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input logic l);
    bit took = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!took && n < 64) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_beat: beat 0x%0h not accepted within %0d cycles", d, n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFFFFFF;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit took;
    bit pending;
    int n;
    int start_cyc;

    // Reset values while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_trunc", out_trunc, 0);
    chk("rst_in_ready", in_ready, 1);
    realign();
    rst_n = 1'b1;

    // 3 + 5 + 7 -> 15, count 3, one cycle after the last beat.
    send_beat(32'd3, 1'b0);
    send_beat(32'd5, 1'b0);
    send_beat(32'd7, 1'b1);
    @(negedge clk);
    chk("sum3_valid", out_valid, 1);
    chk("sum3_data", out_data, 15);
    chk("sum3_count", out_count, 3);
    chk("sum3_ovf", out_ovf, 0);
    chk("sum3_trunc", out_trunc, 0);
    realign();

    // Back-to-back single-beat vectors: one beat (and result) per cycle.
    start_cyc = cyc;
    for (int i = 0; i < 6; i++) send_beat(32'hFFFFFFFF, 1'b1);
    chk("b2b_cycles", cyc - start_cyc, 6);
    @(negedge clk);
    chk("b2b_data", out_data, 32'hFFFFFFFF);
    chk("b2b_count", out_count, 1);
    realign();

    // Hold with out_ready=0 for 4 cycles, final beat pending behind it.
    send_beat(32'd10, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd20;
    in_last   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_data", out_data, 10);
      realign();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    realign();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("release_valid", out_valid, 1);
    chk("release_data", out_data, 20);
    realign();

    // Forced termination at MAX_LEN; the fifth beat opens a new vector.
    for (int i = 0; i < 4; i++) send_beat(32'd1, 1'b0);
    @(negedge clk);
    chk("trunc_data", out_data, 4);
    chk("trunc_count", out_count, 4);
    chk("trunc_flag", out_trunc, 1);
    realign();
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b1);
    @(negedge clk);
    chk("after_trunc_data", out_data, 3);
    chk("after_trunc_count", out_count, 2);
    chk("after_trunc_flag", out_trunc, 0);
    realign();

    // Overflow: 0xFFFFFFFF + 0xFFFFFFFF + 2 exceeds 2^33-1.
    send_beat(32'hFFFFFFFF, 1'b0);
    send_beat(32'hFFFFFFFF, 1'b0);
    send_beat(32'd2, 1'b1);
    @(negedge clk);
    chk("ovf_data", out_data, OVF_RESULT);
    chk("ovf_flag", out_ovf, 1);
    chk("ovf_count", out_count, 3);
    realign();

    // Reset mid-vector discards the partial sum.
    send_beat(32'd4, 1'b0);
    send_beat(32'd6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    realign();
    rst_n = 1'b1;
    send_beat(32'd9, 1'b1);
    @(negedge clk);
    chk("midrst_data", out_data, 9);
    chk("midrst_count", out_count, 1);
    chk("midrst_ovf", out_ovf, 0);
    realign();

    // Randomized traffic with random back-pressure.
    pending = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      realign();
      if (took) pending = 0;
      if (!pending) begin
        if ($urandom_range(0, 9) < 7) begin
          in_data  = rand_data();
          in_last  = ($urandom_range(0, 2) == 0);
          in_valid = 1'b1;
          pending  = 1;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: finish any pending beat, then let results retire.
    out_ready = 1'b1;
    n = 0;
    while (pending && n < 64) begin
      @(negedge clk);
      took = in_valid && in_ready;
      realign();
      if (took) pending = 0;
      n++;
    end
    if (pending) begin
      checks++;
      errors++;
      $display("FAIL drain: pending beat not accepted within %0d cycles", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) realign();
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Streaming accumulator downstream of the two-lane multiply-add pipeline: each beat carries one 32-bit `A1*B1 + A2*B2` partial sum, and the block sums beats until a vector ends, then presents the total with a valid/ready handshake. Turns the pipeline's per-cycle pair products into full dot products of arbitrary length up to `MAX_LEN` beats. Single output register, no FIFO.

## Interface
- `ACC_W`, 40, accumulator and result width (≥ 33).
- `MAX_LEN`, 256, maximum beats per vector; forced termination at this count.
- `CNT_W`, `$clog2(MAX_LEN+1)`, beat-count width (derived, not overridden).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  partial-sum beat present.
- `in_data`  in  32  unsigned partial sum from the multiply-add stage.
- `in_last`  in  1  beat is the final one of its vector.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  ACC_W  dot-product result.
- `out_count`  out  CNT_W  beats in the vector (1..MAX_LEN).
- `out_ovf`  out  1  accumulation exceeded `2^ACC_W-1` at some beat.
- `out_trunc`  out  1  vector closed by `MAX_LEN`, not by `in_last`.

## Operation
- States: IDLE (accumulator empty, no result), ACCUM (≥1 beat summed, no last yet), HOLD (result presented, not yet taken). Partial accumulation may continue in HOLD.
- Accept: `in_ready = ~(out_valid & ~out_ready)`.
- Non-final beat: `acc <= acc + zero-extend(in_data)`, `cnt <= cnt+1`, `ovf_sticky |= carry`; IDLE→ACCUM.
- Final beat (`in_last`, or `cnt+1 == MAX_LEN`): `out_data <= acc + in_data`, `out_count <= cnt+1`, `out_ovf <= ovf_sticky | carry`, `out_trunc <= ~in_last`, `out_valid <= 1`; acc/cnt/sticky cleared; →HOLD.
- Arithmetic unsigned, modulo `2^ACC_W` (see Configuration). `carry` = carry-out of the ACC_W-bit add.
- HOLD→IDLE/ACCUM when `out_ready`, unless a final beat is accepted the same cycle (stays HOLD with new result).
- Reset mid-vector: partial sum discarded, no result emitted.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_count=0`, `out_ovf=0`, `out_trunc=0`; `in_ready=1`; internal acc/cnt/sticky 0; state IDLE.
- Latency: final beat accepted at edge N → `out_valid` high after edge N, result visible cycle N+1.
- Throughput: one beat per cycle; back-to-back single-beat vectors sustain 1 result/cycle while `out_ready=1`.
- `out_valid & ~out_ready`: `in_ready=0`, outputs stable until taken.
- Simultaneous `out_ready` and final-beat accept: old result retires, new result loaded same edge, `out_valid` stays 1.
- `in_valid` with `in_ready=0`: beat ignored; upstream must hold it.

## Configuration
- `DOT_ACCUMULATOR_SAT_EN` defined: on carry the accumulator clamps to `2^ACC_W-1` and stays clamped for the rest of the vector; `out_ovf` still reported.
- Undefined: wrap modulo `2^ACC_W`; `out_ovf` reports that wrap occurred.

## Structure
- Shared package: state enum (IDLE/ACCUM/HOLD), default `ACC_W`/`MAX_LEN` constants, a width function for `CNT_W`.
- One sub-module natural: `dot_acc_adder` — ACC_W-bit add with carry-out and optional saturation (macro-controlled), used for both running and final sums.

## Test plan
- Reset, then beats 3, 5, 7 (last on 7) with `out_ready=1` → `out_data=15`, `out_count=3`, ovf/trunc 0, one cycle after last.
- Single-beat vectors 0xFFFFFFFF every cycle, `out_ready=1` → result 0xFFFFFFFF each cycle, count 1, no bubbles.
- Result held with `out_ready=0` for 4 cycles → `in_ready=0`, outputs stable; release with a final beat pending → new result next cycle, `out_valid` continuous.
- `MAX_LEN=4`, five beats of 1 with no `in_last` → result 4, count 4, `out_trunc=1`; fifth beat starts a new vector.
- `ACC_W=33`, two beats 0xFFFFFFFF then 2 (last) → wrap: `0x000000000`, `out_ovf=1`; with `DOT_ACCUMULATOR_SAT_EN`: `0x1FFFFFFFF`, `out_ovf=1`.
- Assert `rst_n=0` after two beats of a vector, release, send 9 (last) → `out_data=9`, count 1.
